// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache-to-memory arbitration slice: line type,
// arbiter FSM states, client identifiers and the line-offset width.
package lc3b_types;

    // Byte-offset bits inside one 16-byte line; these are zeroed on the memory address.
    localparam int LINE_OFFSET_W = 4;

    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic {
        CLIENT_I = 1'b0,
        CLIENT_D = 1'b1
    } arb_client_t;

endpackage

// File: rtl/cache_arbiter_select.sv
// cache_arb_select: combinational winner pick between the I-cache and
// D-cache requests. With CACHE_ARB_ROUND_ROBIN_EN defined, a tie goes to the
// client that did not win last time; otherwise the D-cache wins every tie.
module cache_arb_select
    import lc3b_types::*;
(
    input  logic        req_i,
    input  logic        req_d,
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    input  arb_client_t last_grant,
`endif
    output logic        grant_valid,
    output arb_client_t grant_client
);

    // Pick the winner among the currently asserted requests.
    always_comb begin
        grant_valid  = req_i | req_d;
        grant_client = CLIENT_I;
        if (req_i && req_d) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            grant_client = (last_grant == CLIENT_I) ? CLIENT_D : CLIENT_I;
`else
            grant_client = CLIENT_D;
`endif
        end else if (req_d) begin
            grant_client = CLIENT_D;
        end else begin
            grant_client = CLIENT_I;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one line-granular memory port between the I-cache
// and the D-cache. One transfer at a time: grant in IDLE, hold the latched
// request in SERVE_x until mem_resp, then a one-cycle RELEASE gap so the
// served cache can drop its request before the next arbitration.
// Optional feature macro: CACHE_ARB_ROUND_ROBIN_EN (round-robin tie break).
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    // Clear the byte offset so memory always sees a line-aligned address.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
    endfunction

    arb_state_t        state_q, state_d;
    logic              op_write_q, op_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              grant_valid;
    arb_client_t       grant_client;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    arb_client_t       last_grant_q, last_grant_d;
`endif

    cache_arb_select u_select (
        .req_i        (i_pmem_read),
        .req_d        (d_pmem_read | d_pmem_write),
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        .last_grant   (last_grant_q),
`endif
        .grant_valid  (grant_valid),
        .grant_client (grant_client)
    );

    // State and latched-request registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            op_write_q   <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            wdata_q      <= {LINE_W{1'b0}};
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            last_grant_q <= CLIENT_I;
`endif
        end else begin
            state_q      <= state_d;
            op_write_q   <= op_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Next state: grant and latch in IDLE, wait for mem_resp, then one release cycle.
    always_comb begin
        state_d      = state_q;
        op_write_d   = op_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    if (grant_client == CLIENT_D) begin
                        state_d    = SERVE_D;
                        // A simultaneous read+write is treated as a write-back.
                        op_write_d = d_pmem_write;
                        addr_d     = line_align(d_pmem_address);
                        wdata_d    = d_pmem_wdata;
                    end else begin
                        state_d    = SERVE_I;
                        op_write_d = 1'b0;
                        addr_d     = line_align(i_pmem_address);
                        wdata_d    = {LINE_W{1'b0}};
                    end
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                    last_grant_d = grant_client;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_d = RELEASE;
                end else begin
                    state_d = state_q;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory strobes and client responses, routed only to the granted cache.
    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        i_pmem_rdata = {LINE_W{1'b0}};
        d_pmem_rdata = {LINE_W{1'b0}};
        case (state_q)
            SERVE_I: begin
                mem_read     = 1'b1;
                i_pmem_resp  = mem_resp;
                i_pmem_rdata = mem_rdata;
            end
            SERVE_D: begin
                mem_read     = ~op_write_q;
                mem_write    = op_write_q;
                d_pmem_resp  = mem_resp;
                d_pmem_rdata = mem_rdata;
            end
            default: begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        endcase
    end

    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model.
module tb_cache_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_pmem_read;
    logic [ADDR_W-1:0] i_pmem_address;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;
    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [ADDR_W-1:0] d_pmem_address;
    logic [LINE_W-1:0] d_pmem_wdata;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    int checks = 0;
    int errors = 0;

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    always #5 clk = ~clk;

    // Transaction-level model: the transfer in flight (if any), a pending
    // release gap, and which client won the last grant.
    logic              m_busy, m_rel, m_cli_d, m_wr, m_lg_d;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_rel = 1'b0; m_cli_d = 1'b0; m_wr = 1'b0; m_lg_d = 1'b0;
        m_addr = '0; m_wdata = '0;
    endtask

    // Apply one clock edge of the arbitration rules to the model.
    task automatic model_step();
        logic ir, dr, pick_d;
        ir = i_pmem_read;
        dr = d_pmem_read | d_pmem_write;
        if (m_rel) begin
            m_rel = 1'b0;
        end else if (m_busy) begin
            if (mem_resp) begin
                m_busy = 1'b0;
                m_rel  = 1'b1;
            end
        end else if (ir || dr) begin
            if (ir && dr) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                pick_d = ~m_lg_d;
`else
                pick_d = 1'b1;
`endif
            end else begin
                pick_d = dr;
            end
            m_busy  = 1'b1;
            m_cli_d = pick_d;
            m_lg_d  = pick_d;
            if (pick_d) begin
                m_wr    = d_pmem_write;
                m_addr  = (d_pmem_address >> 4) << 4;
                m_wdata = d_pmem_wdata;
            end else begin
                m_wr   = 1'b0;
                m_addr = (i_pmem_address >> 4) << 4;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        #1;
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic check_model();
        logic exp_rd, exp_wr, serve_i, serve_d;
        #1;
        exp_rd  = m_busy && !m_wr;
        exp_wr  = m_busy && m_wr;
        serve_i = m_busy && !m_cli_d;
        serve_d = m_busy && m_cli_d;
        chk("mem_read", 128'(mem_read), 128'(exp_rd));
        chk("mem_write", 128'(mem_write), 128'(exp_wr));
        if (m_busy) chk("mem_address", 128'(mem_address), 128'(m_addr));
        if (exp_wr) chk("mem_wdata", mem_wdata, m_wdata);
        chk("i_resp", 128'(i_pmem_resp), 128'(mem_resp && serve_i));
        chk("d_resp", 128'(d_pmem_resp), 128'(mem_resp && serve_d));
        chk("i_rdata", i_pmem_rdata, serve_i ? mem_rdata : 128'd0);
        chk("d_rdata", d_pmem_rdata, serve_d ? mem_rdata : 128'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_read"}, 128'(mem_read), 128'd0);
        chk({tag, "_mem_write"}, 128'(mem_write), 128'd0);
        chk({tag, "_mem_address"}, 128'(mem_address), 128'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 128'd0);
        chk({tag, "_i_resp"}, 128'(i_pmem_resp), 128'd0);
        chk({tag, "_d_resp"}, 128'(d_pmem_resp), 128'd0);
        chk({tag, "_i_rdata"}, i_pmem_rdata, 128'd0);
        chk({tag, "_d_rdata"}, d_pmem_rdata, 128'd0);
    endtask

    initial begin
        logic [127:0] w;
        logic         first_d;
        int           r;

        // Reset state
        reset = 1'b1;
        i_pmem_read = 1'b0; i_pmem_address = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
        mem_rdata = {4{32'h5A5A_1234}}; mem_resp = 1'b0;
        model_reset();
        tick(); tick();
        chk_zero("reset");
        reset = 1'b0;

        // Single I read, memory answers in the third serve cycle
        i_pmem_read = 1'b1; i_pmem_address = 16'h1234;
        check_model();
        chk("idle_no_strobe", 128'(mem_read), 128'd0);
        tick(); check_model();
        chk("i_addr", 128'(mem_address), 128'h1230);
        chk("i_read_strobe", 128'(mem_read), 128'd1);
        tick(); check_model();
        tick();
        mem_resp = 1'b1; mem_rdata = {4{32'hA5A5_A5A5}};
        check_model();
        chk("i_resp_on", 128'(i_pmem_resp), 128'd1);
        chk("i_rdata_val", i_pmem_rdata, {4{32'hA5A5_A5A5}});
        chk("i_other_resp", 128'(d_pmem_resp), 128'd0);
        tick();
        i_pmem_read = 1'b0;
        check_model();
        chk("i_resp_one_cycle", 128'(i_pmem_resp), 128'd0);
        chk("i_release_gap", 128'(mem_read), 128'd0);
        tick(); mem_resp = 1'b0; check_model();

        // Single D write with stable wdata
        w = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        d_pmem_write = 1'b1; d_pmem_address = 16'h0040; d_pmem_wdata = w;
        check_model();
        tick(); check_model();
        chk("d_write_strobe", 128'(mem_write), 128'd1);
        chk("d_wdata", mem_wdata, w);
        chk("d_addr", 128'(mem_address), 128'h0040);
        d_pmem_wdata = ~w;
        tick(); check_model();
        chk("d_wdata_stable", mem_wdata, w);
        tick();
        mem_resp = 1'b1;
        check_model();
        chk("d_resp_on", 128'(d_pmem_resp), 128'd1);
        chk("d_other_resp", 128'(i_pmem_resp), 128'd0);
        tick();
        mem_resp = 1'b0;
        check_model();
        chk("d_release_gap", 128'(mem_write), 128'd0);
        chk("d_resp_one_cycle", 128'(d_pmem_resp), 128'd0);
        d_pmem_write = 1'b0;
        tick(); check_model();

        // Simultaneous requests held for two transfers
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        i_pmem_read = 1'b1; i_pmem_address = 16'h2008;
        d_pmem_read = 1'b1; d_pmem_address = 16'h3FFF;
        check_model();
        tick();
        mem_resp = 1'b1; mem_rdata = {4{32'hC0FF_EE01}};
        check_model();
        chk("tie_first_addr", 128'(mem_address), first_d ? 128'h3FF0 : 128'h2000);
        chk("tie_first_i_resp", 128'(i_pmem_resp), first_d ? 128'd0 : 128'd1);
        chk("tie_first_d_resp", 128'(d_pmem_resp), first_d ? 128'd1 : 128'd0);
        tick();
        mem_resp = 1'b0;
        if (first_d) d_pmem_read = 1'b0; else i_pmem_read = 1'b0;
        check_model();
        tick(); check_model();
        chk("tie_idle_gap", 128'(mem_read), 128'd0);
        tick();
        mem_resp = 1'b1;
        check_model();
        chk("tie_second_addr", 128'(mem_address), first_d ? 128'h2000 : 128'h3FF0);
        chk("tie_second_i_resp", 128'(i_pmem_resp), first_d ? 128'd1 : 128'd0);
        tick();
        mem_resp = 1'b0; i_pmem_read = 1'b0; d_pmem_read = 1'b0;
        check_model();
        tick(); check_model();

        // Illegal D read+write: write wins; spurious mem_resp in IDLE ignored
        d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 16'h0155;
        d_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
        check_model();
        tick();
        mem_resp = 1'b1;
        check_model();
        chk("rw_write", 128'(mem_write), 128'd1);
        chk("rw_no_read", 128'(mem_read), 128'd0);
        chk("rw_addr", 128'(mem_address), 128'h0150);
        tick();
        mem_resp = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        check_model();
        tick();
        mem_resp = 1'b1;
        check_model();
        chk("spur_i_resp", 128'(i_pmem_resp), 128'd0);
        chk("spur_d_resp", 128'(d_pmem_resp), 128'd0);
        tick();
        check_model();
        chk("spur_still_idle", 128'(mem_read | mem_write), 128'd0);
        mem_resp = 1'b0;

        // Asynchronous reset during SERVE_D, then a fresh I read
        d_pmem_read = 1'b1; d_pmem_address = 16'h0ABC;
        tick(); check_model();
        chk("rst_pre_read", 128'(mem_read), 128'd1);
        #1;
        mem_resp = 1'b1; mem_rdata = {4{32'hDEAD_BEEF}};
        reset = 1'b1;
        #1;
        chk_zero("async_rst");
        tick();
        reset = 1'b0; d_pmem_read = 1'b0; mem_resp = 1'b0;
        i_pmem_read = 1'b1; i_pmem_address = 16'h0777;
        check_model();
        tick(); check_model();
        chk("post_rst_addr", 128'(mem_address), 128'h0770);
        chk("post_rst_read", 128'(mem_read), 128'd1);
        tick();
        mem_resp = 1'b1;
        check_model();
        chk("post_rst_resp", 128'(i_pmem_resp), 128'd1);
        tick();
        i_pmem_read = 1'b0; mem_resp = 1'b0;
        check_model();
        tick(); check_model();

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            tick();
            if ($urandom_range(3, 0) == 0) i_pmem_read = 1'($urandom_range(1, 0));
            if ($urandom_range(3, 0) == 0) begin
                r = $urandom_range(7, 0);
                d_pmem_read  = (r == 1) || (r == 3);
                d_pmem_write = (r == 2) || (r == 3);
            end
            i_pmem_address = 16'($urandom);
            d_pmem_address = 16'($urandom);
            d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
            mem_rdata      = {$urandom, $urandom, $urandom, $urandom};
            mem_resp       = ($urandom_range(2, 0) == 0);
            check_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates the line-granular physical-memory ports of the instruction cache and the data cache onto one shared memory port. Sits directly downstream of both cache datapaths' `pmem_*` signals and upstream of physical memory or L2. Serves one 128-bit line transfer at a time. Latches the winning request and routes the response back only to the granted cache.

## Interface
- `ADDR_W`, default 16: byte address width.
- `LINE_W`, default 128: cache line width in bits.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `i_pmem_read` in 1: I-cache line read request (I-cache never writes).
- `i_pmem_address` in ADDR_W: I-cache line address.
- `i_pmem_rdata` out LINE_W: line returned to the I-cache.
- `i_pmem_resp` out 1: I-cache transfer complete.
- `d_pmem_read` in 1: D-cache line read request.
- `d_pmem_write` in 1: D-cache write-back request.
- `d_pmem_address` in ADDR_W: D-cache line address.
- `d_pmem_wdata` in LINE_W: D-cache victim line.
- `d_pmem_rdata` out LINE_W: line returned to the D-cache.
- `d_pmem_resp` out 1: D-cache transfer complete.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_address` out ADDR_W: line address, with bits [3:0] forced to 0.
- `mem_wdata` out LINE_W: write line.
- `mem_rdata` in LINE_W: read line.
- `mem_resp` in 1: memory transfer complete.

## Operation
- State machine with states IDLE, SERVE_I, SERVE_D and RELEASE.
- **IDLE.** Evaluate requests each cycle.
  - Exactly one client requesting: grant it.
  - Both requesting: the selection policy decides (see Configuration).
  - On grant, register the op, the address (with [3:0] zeroed) and the wdata. Move to SERVE_I or SERVE_D.
- **SERVE_x.** Drive `mem_read`/`mem_write` and `mem_address`/`mem_wdata` from the registers, held stable until `mem_resp`.
  - Client response is combinational: `x_pmem_resp = mem_resp & (state==SERVE_x)`.
  - `x_pmem_rdata = mem_rdata` whenever state==SERVE_x, else 0.
  - On `mem_resp`, go to RELEASE.
- **RELEASE.** One cycle with no grant and no memory strobes, so the served cache's controller can drop its request. Then go to IDLE.
- `d_pmem_read` and `d_pmem_write` asserted together is illegal. If it occurs, write takes priority.
- A request that drops before being granted is simply not served. Requests are never queued.
- The non-granted client's `pmem_resp` stays 0 throughout. Its request stays pending and is re-evaluated in the next IDLE.
- Reset (asynchronous) forces:
  - state = IDLE;
  - all registered op/address/wdata = 0;
  - all outputs 0: `mem_read`, `mem_write`, `mem_address`, `mem_wdata`, both `*_pmem_resp`, both `*_pmem_rdata`;
  - `last_grant` = I.
- Reset mid-transfer aborts the transfer. No response is issued. The memory model must tolerate strobe deassertion.

## Timing
- Request seen in IDLE at cycle N → memory strobes asserted from cycle N+1.
- `mem_resp` in cycle M → `x_pmem_resp` in cycle M (same cycle, zero added latency). RELEASE in M+1. Earliest next grant evaluated in M+2.
- Minimum occupancy per transfer: 1 (grant) + memory latency + 1 (release) cycles.
- `mem_resp` outside SERVE_x is ignored.
- Back-to-back D-cache write-back then fill:
  - the write is granted first;
  - the read is granted in the IDLE following RELEASE;
  - if the I-cache is pending, the policy decides.

## Configuration
- `CACHE_ARB_ROUND_ROBIN_EN` defined:
  - on a simultaneous request, grant the client not recorded in `last_grant`;
  - `last_grant` updates at every grant.
- Not defined: fixed priority, with the D-cache always winning ties. The `last_grant` register is not built. The I-cache can starve under continuous D-cache traffic; this is accepted.

## Structure
- Shared `lc3b_types` package:
  - `lc3b_line` (logic [127:0]) typedef;
  - `arb_state_t` enum (IDLE, SERVE_I, SERVE_D, RELEASE);
  - `arb_client_t` enum (CLIENT_I, CLIENT_D).
- One sub-module, `cache_arb_select`: a combinational winner pick from the two request vectors, `last_grant` and the policy macro. Outputs a grant-valid bit and the client.
- The FSM, the request registers and the response routing stay in `cache_arbiter`.

## Test plan
- **Single I read.** `i_pmem_read` with addr 0x1234, memory responds after 3 cycles with data 0xA5..A5.
  - `mem_address` = 0x1230 from the next cycle.
  - `i_pmem_resp` asserted for 1 cycle with 0xA5..A5.
  - `d_pmem_resp` stays 0.
- **Single D write.** `d_pmem_write` with addr 0x0040 and data 0x0123..CDEF.
  - `mem_write` = 1 and `mem_wdata` matches, stable until `mem_resp`.
  - `d_pmem_resp` asserted for 1 cycle.
  - A 1-cycle RELEASE gap follows.
- **Simultaneous requests, both held for two transfers.**
  - Fixed priority: D granted first, then I.
  - With `CACHE_ARB_ROUND_ROBIN_EN` and `last_grant` = D: I first, then D.
- **Illegal D read+write together.** A write is issued. Also: a spurious `mem_resp` in IDLE causes no client response.
- **Reset during SERVE_D.** All outputs read 0 immediately (asynchronous). State returns to IDLE. A fresh I request is granted normally after reset deasserts.
